// File: rtl/pcm_pkg.sv
// Shared PCM sample types for the FIR decimator output path.
package pcm_pkg;
  localparam int SAMPLE_W  = 16;
  localparam int DROPCNT_W = 8;

  typedef logic signed [SAMPLE_W-1:0] sample_t;
endpackage

// File: rtl/pcm_fifo_mem.sv
// Sample storage: sync write, async read register array.
module pcm_fifo_mem
  import pcm_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int DW    = SAMPLE_W,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          Clock,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge Clock) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pcm_out_fifo.sv
// FWFT output FIFO behind the FIR decimator; drops on overflow.
// Define PCM_OUT_FIFO_DROP_OLDEST_EN to overwrite the oldest entry instead.
module pcm_out_fifo
  import pcm_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int DW        = SAMPLE_W,
  parameter int AFULL_LVL = 12,
  localparam int AW       = $clog2(DEPTH),
  localparam int CW       = AW + 1
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 Push,
  input  logic [DW-1:0]        Din,
  output logic                 Dout_valid,
  input  logic                 Dout_ready,
  output logic [DW-1:0]        Dout,
  output logic [CW-1:0]        Count,
  output logic                 Empty,
  output logic                 Full,
  output logic                 AlmostFull,
  output logic                 Overflow,
  input  logic                 ClrOvf,
  output logic [DROPCNT_W-1:0] DropCnt
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AFULL_LVL);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [DROPCNT_W-1:0] DC_MAX = '1;
  localparam logic [DROPCNT_W-1:0] DC_ONE = DROPCNT_W'(1);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [DROPCNT_W-1:0] drop_q, drop_d;

  logic          pop, accept, drop;
  logic          we, rd_adv;
  logic [DW-1:0] rdata;

  assign Empty      = (count_q == '0);
  assign Full       = (count_q == FULL_CNT);
  assign AlmostFull = (count_q >= AF_CNT);
  assign Count      = count_q;
  assign Overflow   = ovf_q;
  assign DropCnt    = drop_q;
  assign Dout_valid = !Empty;
  assign Dout       = Empty ? '0 : rdata;

  assign pop    = !Empty && Dout_ready;
  assign accept = Push && (!Full || pop);
  assign drop   = Push && Full && !pop;

`ifdef PCM_OUT_FIFO_DROP_OLDEST_EN
  // Overwrite the head slot and slide the window forward.
  assign we     = accept || drop;
  assign rd_adv = pop || drop;
`else
  assign we     = accept;
  assign rd_adv = pop;
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    drop_d   = drop_q;

    if (we)     wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_adv) rd_ptr_d = rd_ptr_q + PTR_ONE;

    if (accept && !pop)      count_d = count_q + CNT_ONE;
    else if (pop && !accept) count_d = count_q - CNT_ONE;

    // A drop in the same cycle as a clear restarts the tally at one.
    if (drop) begin
      ovf_d = 1'b1;
      if (ClrOvf)               drop_d = DC_ONE;
      else if (drop_q != DC_MAX) drop_d = drop_q + DC_ONE;
    end else if (ClrOvf) begin
      ovf_d  = 1'b0;
      drop_d = '0;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
    end
  end

  pcm_fifo_mem #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_mem (
    .Clock   (Clock),
    .we_i    (we),
    .waddr_i (wr_ptr_q),
    .wdata_i (Din),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata)
  );

endmodule

// File: doc/pcm_out_fifo.md
Name: pcm_out_fifo

Overview:
- Downstream stage of the 1-bit symmetric FIR decimator.
- Captures each 16-bit filtered sample presented on the filter's Dout/Push pulse and buffers it in a small FIFO.
- Drains samples to the consumer (DAC/serial/bus bridge) over a valid/ready handshake.
- Flags overflow, because the filter never back-pressures: Push is a one-cycle pulse that cannot be stalled.

Parameters:
- DEPTH, 16, number of sample entries; power of 2, min 2.
- DW, 16, sample width; matches filter Dout.
- AFULL_LVL, 12, occupancy at or above which AlmostFull asserts; must be < DEPTH.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Push  in  1  one-cycle write strobe from filter.
- Din  in  DW  sample from filter Dout; valid when Push=1.
- Dout_valid  out  1  head sample available.
- Dout_ready  in  1  consumer accepts head sample.
- Dout  out  DW  head sample.
- Count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- Empty  out  1  Count==0.
- Full  out  1  Count==DEPTH.
- AlmostFull  out  1  Count>=AFULL_LVL.
- Overflow  out  1  sticky: a write was lost.
- ClrOvf  in  1  synchronous clear of Overflow and DropCnt.
- DropCnt  out  8  saturating count of dropped samples.

Behaviour:
- Reset is asynchronous and active-high; the clock is Clock.
- On Reset, regardless of operation in flight:
  - wr_ptr, rd_ptr and Count return to 0.
  - Stored contents are discarded.
  - Dout_valid=0, Dout=0, Empty=1, Full=0, AlmostFull=0, Overflow=0, DropCnt=0.
- First-word-fall-through:
  - Dout_valid = !Empty.
  - Dout = mem[rd_ptr] when valid, forced 0 when Empty.
- Pop: occurs on a rising edge with Dout_valid && Dout_ready. rd_ptr advances by 1.
- Write acceptance: accept = Push && (!Full || pop). On acceptance, mem[wr_ptr] <= Din and wr_ptr advances by 1.
  - Push and pop together while Full: both happen and Count is unchanged.
- Latency: a sample accepted at edge N has Dout_valid=1 and appears on Dout after edge N. There is no same-cycle bypass while Empty.
- Count update: +1 for accept only, -1 for pop only, unchanged for both or neither.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Drop (Push && Full && !pop), default behaviour:
  - The new sample is discarded; FIFO contents and pointers are unchanged.
  - Overflow <= 1.
  - DropCnt increments, saturating at 255.
- ClrOvf:
  - Clears Overflow and zeroes DropCnt on the next edge.
  - If a drop occurs in the same cycle: Overflow=1 and DropCnt=1. The new event wins.
- Dout_ready while Empty is ignored and has no effect.
- Flag timing: Empty, Full and AlmostFull are combinational decodes of registered Count, so they change together with Count.
- Storage: inferred dual-port register array, synchronous write, asynchronous read. No reset of array contents is required.

Optional Feature:
- Macro: PCM_OUT_FIFO_DROP_OLDEST_EN.
- When defined, a drop case instead does all of the following:
  - overwrites the oldest entry;
  - writes mem[wr_ptr] <= Din and advances both wr_ptr and rd_ptr;
  - leaves Count at DEPTH;
  - sets Overflow and increments DropCnt as before.
  - Net effect: the consumer always sees the newest DEPTH samples.
- When undefined: the newest sample is dropped, as specified above.

Decomposition:
- Package pcm_pkg holds:
  - localparam SAMPLE_W = 16;
  - typedef logic signed [SAMPLE_W-1:0] sample_t, shared with the filter's Dout;
  - localparam DROPCNT_W = 8.
- One natural sub-module, pcm_fifo_mem: DEPTH x DW array with write port (we, waddr, wdata) and async read port (raddr, rdata).
- Pointer, count, flag and overflow logic stay in pcm_out_fifo.

Test Plan:
- Reset, then Push 0x1234 with Dout_ready=0 -> next cycle Dout_valid=1, Dout=0x1234, Count=1, Empty=0. Then Dout_ready=1 for one cycle -> Count=0, Dout=0, Dout_valid=0.
- Push 16 samples 0x0001..0x0010 back-to-back with ready=0 -> Full=1, Count=16, AlmostFull asserts after the 12th write. Drain with ready=1 -> Dout yields 0x0001..0x0010 in order, then Empty=1.
- Fill to 16, Push 0xBEEF with ready=0 -> Overflow=1, DropCnt=1, Count=16, head still 0x0001.
  - With PCM_OUT_FIFO_DROP_OLDEST_EN defined: head becomes 0x0002 and the last entry is 0xBEEF.
- Full, Push 0xAAAA together with ready=1 -> 0x0001 popped, 0xAAAA accepted, Count stays 16, Overflow stays 0.
- Force 300 drops -> DropCnt=255 (saturated). ClrOvf together with one more drop -> Overflow=1, DropCnt=1. ClrOvf alone -> Overflow=0, DropCnt=0.
- Assert Reset mid-drain with Count=7 -> immediately Count=0, Dout_valid=0, Dout=0, Overflow=0. The first Push after release returns its own value on Dout.
